// File: rtl/cell_window_packer.sv
// cell_window_packer: gathers CELL_DIM x CELL_DIM pixels per channel into one flat
// cell vector, hands it to the cell processor with an opcode, then captures the
// processor's single result pixel and forwards it downstream with its own handshake.
module cell_window_packer #(
    parameter int CELL_DIM = 3,
    parameter int PIXEL_W  = 24,
    parameter int NUM_CH   = 2,
    parameter int OPC_W    = 4,
    parameter int CNT_W    = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [NUM_CH*PIXEL_W-1:0]                 in_pix,
    input  logic [OPC_W-1:0]                          in_opcode,
    input  logic                                      in_last,
    output logic                                      cell_valid,
    input  logic                                      cell_ready,
    output logic [NUM_CH*CELL_DIM*CELL_DIM*PIXEL_W-1:0] cell_data,
    output logic [OPC_W-1:0]                          cell_opcode,
    input  logic                                      res_valid,
    input  logic [PIXEL_W-1:0]                        res_pixel,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [PIXEL_W-1:0]                        out_pixel,
    output logic                                      frame_done,
    output logic [CNT_W-1:0]                          cell_count,
    output logic                                      res_err
);

    localparam int CELL_PIX = CELL_DIM * CELL_DIM;
    localparam int BEAT_W   = (CELL_PIX > 1) ? $clog2(CELL_PIX) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CELL_PIX - 1);

    typedef enum logic [1:0] {FILL, ISSUE, WAIT, OUT} state_t;

    state_t            state;
    logic [BEAT_W-1:0] beat;
    logic              last_flag;
    logic              accept;

    // in_ready is registered and only ever high in FILL, so this is a FILL-state accept
    assign accept = in_valid & in_ready;

    // Single FSM: fill slots, issue cell, wait for result, present result downstream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FILL;
            beat        <= '0;
            last_flag   <= 1'b0;
            in_ready    <= 1'b0;
            cell_valid  <= 1'b0;
            cell_data   <= '0;
            cell_opcode <= '0;
            out_valid   <= 1'b0;
            out_pixel   <= '0;
            frame_done  <= 1'b0;
            cell_count  <= '0;
            res_err     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (res_valid && state != WAIT) begin
                res_err <= 1'b1;
            end
            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            cell_data[(c*CELL_PIX + int'(beat))*PIXEL_W +: PIXEL_W]
                                <= in_pix[c*PIXEL_W +: PIXEL_W];
                        end
                        if (beat == '0) begin
                            cell_opcode <= in_opcode;
                        end
                        if (beat == LAST_BEAT) begin
                            last_flag  <= in_last;
                            beat       <= '0;
                            in_ready   <= 1'b0;
                            cell_valid <= 1'b1;
                            state      <= ISSUE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (cell_ready) begin
                        cell_valid <= 1'b0;
                        cell_data  <= '0;
                        if (cell_count != '1) begin
                            cell_count <= cell_count + 1'b1;
                        end
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (res_valid) begin
                        out_pixel <= res_pixel;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= FILL;
                        if (last_flag) begin
                            frame_done <= 1'b1;
                            cell_count <= '0;
                            last_flag  <= 1'b0;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_window_packer.sv
// Testbench for cell_window_packer: directed vectors on a default-parameter instance
// plus a single-channel 5x5 / 8-bit instance for the wide-cell layout.
module tb_cell_window_packer;

    logic clk;
    logic rst;

    // default instance: CELL_DIM=3, PIXEL_W=24, NUM_CH=2
    logic          d_in_valid, d_in_ready, d_in_last;
    logic [47:0]   d_in_pix;
    logic [3:0]    d_in_opcode, d_cell_opcode;
    logic          d_cell_valid, d_cell_ready;
    logic [431:0]  d_cell_data;
    logic          d_res_valid, d_out_valid, d_out_ready, d_frame_done, d_res_err;
    logic [23:0]   d_res_pixel, d_out_pixel;
    logic [15:0]   d_cell_count;

    // small instance: CELL_DIM=5, PIXEL_W=8, NUM_CH=1
    logic          s_in_valid, s_in_ready, s_in_last;
    logic [7:0]    s_in_pix;
    logic [3:0]    s_in_opcode, s_cell_opcode;
    logic          s_cell_valid, s_cell_ready;
    logic [199:0]  s_cell_data;
    logic          s_res_valid, s_out_valid, s_out_ready, s_frame_done, s_res_err;
    logic [7:0]    s_res_pixel, s_out_pixel;
    logic [15:0]   s_cell_count;

    int errCount   = 0;
    int checkCount = 0;

    cell_window_packer dut (
        .clk(clk), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_pix(d_in_pix),
        .in_opcode(d_in_opcode), .in_last(d_in_last),
        .cell_valid(d_cell_valid), .cell_ready(d_cell_ready), .cell_data(d_cell_data),
        .cell_opcode(d_cell_opcode),
        .res_valid(d_res_valid), .res_pixel(d_res_pixel),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_pixel(d_out_pixel),
        .frame_done(d_frame_done), .cell_count(d_cell_count), .res_err(d_res_err)
    );

    cell_window_packer #(.CELL_DIM(5), .PIXEL_W(8), .NUM_CH(1)) dut_small (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_pix(s_in_pix),
        .in_opcode(s_in_opcode), .in_last(s_in_last),
        .cell_valid(s_cell_valid), .cell_ready(s_cell_ready), .cell_data(s_cell_data),
        .cell_opcode(s_cell_opcode),
        .res_valid(s_res_valid), .res_pixel(s_res_pixel),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_pixel(s_out_pixel),
        .frame_done(s_frame_done), .cell_count(s_cell_count), .res_err(s_res_err)
    );

    // 10-unit clock period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected default-instance cell: slot k of ch0 = b0+k, of ch1 = b1+k
    function automatic logic [431:0] expCell(input logic [23:0] b0, input logic [23:0] b1);
        logic [431:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) begin
            v[k*24 +: 24]     = b0 + 24'(k);
            v[(9+k)*24 +: 24] = b1 + 24'(k);
        end
        return v;
    endfunction

    // one beat on the default instance; called and returns at #1 after a rising edge
    task automatic sendBeat(input logic [23:0] p0, input logic [23:0] p1,
                            input logic [3:0] op, input logic last);
        int guard;
        guard = 0;
        d_in_valid  = 1'b1;
        d_in_pix    = {p1, p0};
        d_in_opcode = op;
        d_in_last   = last;
        while (!d_in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!d_in_ready) checkOutput("beat_timeout", d_in_ready, 1);
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        d_in_last  = 1'b0;
    endtask

    // nine beats; opcode valid only on beat 0, in_last only on beat lastBeat
    task automatic applyStimulus(input logic [23:0] b0, input logic [23:0] b1,
                                 input logic [3:0] op, input int lastBeat);
        for (int k = 0; k < 9; k++) begin
            sendBeat(b0 + 24'(k), b1 + 24'(k), (k == 0) ? op : ~op, k == lastBeat);
        end
    endtask

    task automatic handshakeCell();
        int guard;
        guard = 0;
        d_cell_ready = 1'b1;
        while (!d_cell_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!d_cell_valid) checkOutput("issue_timeout", d_cell_valid, 1);
        @(posedge clk); #1;
        d_cell_ready = 1'b0;
    endtask

    task automatic returnResult(input logic [23:0] pix);
        d_res_valid = 1'b1;
        d_res_pixel = pix;
        @(posedge clk); #1;
        d_res_valid = 1'b0;
    endtask

    task automatic takeOut(input int delay);
        repeat (delay) @(posedge clk);
        #1;
        d_out_ready = 1'b1;
        @(posedge clk); #1;
        d_out_ready = 1'b0;
    endtask

    // directed sequence
    initial begin
        logic [431:0] held;
        int guard;
        rst = 1'b0;
        d_in_valid = 0; d_in_pix = '0; d_in_opcode = '0; d_in_last = 0;
        d_cell_ready = 0; d_res_valid = 0; d_res_pixel = '0; d_out_ready = 0;
        s_in_valid = 0; s_in_pix = '0; s_in_opcode = '0; s_in_last = 0;
        s_cell_ready = 0; s_res_valid = 0; s_res_pixel = '0; s_out_ready = 0;

        #1;
        checkOutput("rst_in_ready", d_in_ready, 0);
        checkOutput("rst_cell_valid", d_cell_valid, 0);
        checkOutput("rst_cell_data", d_cell_data, 0);
        checkOutput("rst_out", {d_out_valid, d_out_pixel, d_frame_done, d_res_err}, 0);
        checkOutput("rst_count", d_cell_count, 0);
        #22 rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("in_ready_after_rst", d_in_ready, 1);

        // cell 1 held in ISSUE for 10 cycles, then released
        applyStimulus(24'h1, 24'h100, 4'h3, -1);
        checkOutput("c1_cell_valid", d_cell_valid, 1);
        checkOutput("c1_in_ready", d_in_ready, 0);
        checkOutput("c1_data", d_cell_data, expCell(24'h1, 24'h100));
        checkOutput("c1_opcode", d_cell_opcode, 4'h3);
        held = d_cell_data;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("hold_cell_valid", d_cell_valid, 1);
        checkOutput("hold_in_ready", d_in_ready, 0);
        checkOutput("hold_data", d_cell_data, expCell(24'h1, 24'h100));
        checkOutput("hold_count", d_cell_count, 0);
        handshakeCell();
        checkOutput("c1_valid_drop", d_cell_valid, 0);
        checkOutput("c1_count", d_cell_count, 1);
        checkOutput("c1_data_clear", d_cell_data, 0);
        returnResult(24'h123456);
        checkOutput("c1_out_valid", d_out_valid, 1);
        checkOutput("c1_out_pixel", d_out_pixel, 24'h123456);
        takeOut(0);
        checkOutput("c1_out_drop", d_out_valid, 0);
        checkOutput("c1_no_frame_done", d_frame_done, 0);
        checkOutput("c1_back_fill", d_in_ready, 1);

        // stray result strobe during FILL
        d_res_valid = 1'b1; d_res_pixel = 24'h777777;
        @(posedge clk); #1;
        d_res_valid = 1'b0;
        checkOutput("stray_res_err", d_res_err, 1);
        checkOutput("stray_in_ready", d_in_ready, 1);
        checkOutput("stray_out", {d_out_valid, d_out_pixel}, {1'b0, 24'h123456});

        // cell 2: in_last on beat 2 must be ignored
        applyStimulus(24'h10, 24'h20, 4'h5, 2);
        checkOutput("c2_opcode", d_cell_opcode, 4'h5);
        handshakeCell();
        checkOutput("c2_count", d_cell_count, 2);
        returnResult(24'h000111);
        takeOut(1);
        checkOutput("c2_no_frame_done", d_frame_done, 0);
        checkOutput("c2_count_kept", d_cell_count, 2);

        // cell 3: last cell of frame
        applyStimulus(24'h30, 24'h40, 4'h9, 8);
        handshakeCell();
        checkOutput("c3_count", d_cell_count, 3);
        returnResult(24'hABCDEF);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("c3_out_wait", d_out_valid, 1);
        takeOut(0);
        checkOutput("c3_frame_done", d_frame_done, 1);
        checkOutput("c3_count_clear", d_cell_count, 0);
        checkOutput("c3_out_pixel", d_out_pixel, 24'hABCDEF);
        @(posedge clk); #1;
        checkOutput("c3_frame_done_pulse", d_frame_done, 0);
        checkOutput("c3_out_pixel_hold", d_out_pixel, 24'hABCDEF);
        checkOutput("c3_res_err_sticky", d_res_err, 1);

        // reset after 5 beats of a partial cell
        for (int k = 0; k < 5; k++) begin
            sendBeat(24'hAAAA00 + 24'(k), 24'hBBBB00 + 24'(k), 4'hE, 1'b1);
        end
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", d_in_ready, 0);
        checkOutput("mid_rst_data", d_cell_data, 0);
        checkOutput("mid_rst_misc", {d_cell_valid, d_out_valid, d_out_pixel, d_res_err, d_cell_count}, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        applyStimulus(24'h200, 24'h300, 4'h6, -1);
        checkOutput("fresh_data", d_cell_data, expCell(24'h200, 24'h300));
        checkOutput("fresh_opcode", d_cell_opcode, 4'h6);
        handshakeCell();
        checkOutput("fresh_count", d_cell_count, 1);

        // 5x5 single-channel 8-bit cell
        for (int k = 0; k < 25; k++) begin
            guard = 0;
            s_in_valid = 1'b1;
            s_in_pix   = 8'h10 + 8'(k);
            while (!s_in_ready && guard < 20) begin
                @(posedge clk); #1;
                guard++;
            end
            if (!s_in_ready) checkOutput("small_beat_timeout", s_in_ready, 1);
            @(posedge clk); #1;
            s_in_valid = 1'b0;
        end
        begin
            logic [199:0] sexp;
            for (int k = 0; k < 25; k++) sexp[k*8 +: 8] = 8'h10 + 8'(k);
            checkOutput("small_cell_valid", s_cell_valid, 1);
            checkOutput("small_data", s_cell_data, sexp);
            checkOutput("small_slot24", s_cell_data[199:192], 8'h28);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
